hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Sequential multiply/divide engine plus architectural HI/LO register pair.
- Sits beside the combinational ALU in the execute stage.
- Accepts the same MULT/MULTU/DIV/DIVU opcodes.
- Computes the 64-bit result iteratively, commits it to HI/LO, and serves MFHI/MFLO reads and MTHI/MTLO writes.
- Drives a busy/done handshake so the pipeline can stall on HI/LO hazards.

Parameters:
- WIDTH, 32, operand width. HI/LO are WIDTH each; iterative latency scales with WIDTH.

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe; sampled on rising clk edge.
- op  in  4  operation code: 4'b0000 MULT, 4'b1001 MULTU, 4'b1101 DIV, 4'b1100 DIVU.
- op1  in  WIDTH  multiplicand / dividend.
- op2  in  WIDTH  multiplier / divisor.
- mthi  in  1  write mt_data to HI.
- mtlo  in  1  write mt_data to LO.
- mt_data  in  WIDTH  MTHI/MTLO data.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO are committed.
- div_by_zero  out  1  pulses with done when a DIV/DIVU had op2==0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset:
  - rst_n low immediately forces state=IDLE.
  - busy=0, done=0, div_by_zero=0, hi=0, lo=0.
  - All working registers cleared.
- States:
  - IDLE --start & valid op--> CALC.
  - CALC: WIDTH iterations, one per clk --> FIX.
  - FIX: one cycle --> IDLE, with the done pulse.
- Operand capture: op, op1 and op2 are latched at the accepting edge (T0). Inputs may change afterwards.
- Signed ops: operate on absolute values; record sign flags at T0.
- Multiply: radix-2 shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
- Divide: restoring, one quotient bit per cycle.
- FIX (sign correction):
  - MULT: product negated if signs differ.
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend (truncating division).
  - MULT/MULTU commit hi=product[2W-1:W], lo=product[W-1:0].
  - DIV/DIVU commit lo=quotient, hi=remainder.
- Latency:
  - start sampled at edge T0; busy=1 from after T0 through the FIX cycle.
  - hi/lo updated and done=1 in the cycle after edge T0+WIDTH+1 (edge 33 for WIDTH=32); busy=0 in that cycle.
- Hold: hi/lo keep their previous values during CALC/FIX. Working state is separate.
- Divide by zero (op2==0): lo=all ones, hi=op1 (raw), div_by_zero=1 with done. Still full latency.
- Signed overflow, 0x80000000 / -1: lo=0x80000000, hi=0. No flag.
- start while busy: ignored, no queueing.
- start with an invalid op: ignored, state stays IDLE.
- mthi/mtlo:
  - Accepted only in IDLE; register written at the next edge.
  - Ignored while busy; the pipeline must stall on busy.
  - mthi and mtlo together: both written.
  - start with a valid op plus mthi/mtlo in the same cycle: start wins, mt write dropped.
  - mt write in the done cycle (state IDLE) is accepted.
- done and div_by_zero: exactly one cycle high.
- rst_n asserted mid-operation: operation aborted, no done, hi=lo=0.

Optional Feature:
- Macro: FAST_MULT_EN.
- Defined:
  - MULT/MULTU use a single-cycle combinational 2*WIDTH multiplier.
  - Result committed at edge T0+1; done high in the following cycle; busy high for exactly one cycle.
  - DIV/DIVU unchanged.
- Undefined: all ops use the iterative path with the latency above.

Test Plan:
- MULTU op1=0xFFFFFFFF, op2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly one cycle, after edge 33 (edge 1 with FAST_MULT_EN).
- MULT op1=0xFFFFFFFD (-3), op2=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV op1=0xFFFFFFF9 (-7), op2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIVU op1=100, op2=0 -> lo=0xFFFFFFFF, hi=100, div_by_zero=1 coincident with done.
- mthi=1, mt_data=0x12345678 in IDLE -> hi=0x12345678 next cycle. During a busy DIVU: assert mtlo and a second start -> both ignored, lo equals the DIVU quotient only.
- Start MULTU, deassert rst_n at cycle 10 -> busy, hi and lo go to 0 immediately. After release, no done pulse; a new start completes normally.

Source files
------------

// File: rtl/hilo_muldiv_if.sv
// Execute-stage request/response bundle for the HI/LO multiply/divide unit.
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] mt_data;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, op1, op2, mthi, mtlo, mt_data,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, op1, op2, mthi, mtlo, mt_data,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO and MTHI/MTLO.
// Define FAST_MULT_EN to replace the iterative multiply with a single-cycle multiplier.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst_n,
    hilo_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1100;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state_q, state_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     raw_q, raw_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;

    logic                 op_valid, op_div, op_sgn, a_neg, b_neg;
    logic [WIDTH-1:0]     a_abs, b_abs, addend;
    logic [WIDTH:0]       sum, shifted, diff;
    logic [2*WIDTH-1:0]   prod_fix;
`ifdef FAST_MULT_EN
    logic [2*WIDTH-1:0]   prod_fast;
`endif

    function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    assign op_valid = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                      (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign op_div   = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign op_sgn   = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign a_neg    = op_sgn & bus.op1[WIDTH-1];
    assign b_neg    = op_sgn & bus.op2[WIDTH-1];
    assign a_abs    = cneg_w(bus.op1, a_neg);
    assign b_abs    = cneg_w(bus.op2, b_neg);
`ifdef FAST_MULT_EN
    assign prod_fast = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
`endif

    // Shift-add step: acc = {partial product, remaining multiplier bits}.
    assign addend  = acc_q[0] ? b_q : {WIDTH{1'b0}};
    assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    // Restoring step: acc = {partial remainder, remaining dividend / quotient bits}.
    assign shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, b_q};
    assign prod_fix = cneg_2w(acc_q, neg_res_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        b_d       = b_q;
        raw_d     = raw_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && op_valid) begin
                    is_div_d  = op_div;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dz_d      = op_div && (bus.op2 == '0);
                    b_d       = b_abs;
                    raw_d     = bus.op1;
                    acc_d     = {{WIDTH{1'b0}}, a_abs};
                    cnt_d     = '0;
                    state_d   = CALC;
`ifdef FAST_MULT_EN
                    if (!op_div) begin
                        acc_d   = prod_fast;
                        state_d = FIX;
                    end
`endif
                end else begin
                    if (bus.mthi) hi_d = bus.mt_data;
                    if (bus.mtlo) lo_d = bus.mt_data;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else              acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    if (dz_q) begin
                        lo_d  = {WIDTH{1'b1}};
                        hi_d  = raw_q;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = cneg_w(acc_q[WIDTH-1:0], neg_res_q);
                        hi_d = cneg_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
                    end
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            b_q       <= '0;
            raw_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            b_q       <= b_d;
            raw_q     <= raw_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized and directed bench for hilo_muldiv_unit against an arithmetic reference model.
module tb_hilo_muldiv_unit;
    localparam int WIDTH = 32;
    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1100;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] hi_m, lo_m;

    hilo_muldiv_if #(.WIDTH(WIDTH)) bus ();

    hilo_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {div_by_zero, hi, lo} from plain arithmetic.
    function automatic logic [64:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              q, r;
        logic [64:0]     res;
        res = '0;
        case (o)
            OP_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                res = {1'b0, sp[63:0]};
            end
            OP_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                res = {1'b0, up[63:0]};
            end
            OP_DIV: begin
                if (b == 0) res = {1'b1, a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {1'b0, 32'h0, 32'h8000_0000};
                else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    res = {1'b0, r, q};
                end
            end
            OP_DIVU: begin
                if (b == 0) res = {1'b1, a, 32'hFFFF_FFFF};
                else res = {1'b0, a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, input bit mt_with_start, input bit mt_in_done);
        logic [64:0] e;
        int          k;
        int          lat;
        bit          ok;
        logic [31:0] d;
        e   = model(o, a, b);
        lat = WIDTH + 1;
`ifdef FAST_MULT_EN
        if (o == OP_MULT || o == OP_MULTU) lat = 1;
`endif
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.op1 = a; bus.op2 = b;
        if (mt_with_start) begin
            bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.mt_data = $urandom;
        end
        @(negedge clk);
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        bus.op = 4'($urandom); bus.op1 = $urandom; bus.op2 = $urandom;
        k  = 0;
        ok = 1'b1;
        while (bus.done !== 1'b1 && k < 200) begin
            if (bus.busy !== 1'b1 || bus.hi !== hi_m || bus.lo !== lo_m) ok = 1'b0;
            if (disturb && k == 3) begin
                bus.start = 1'b1; bus.op = OP_MULTU; bus.mtlo = 1'b1; bus.mt_data = $urandom;
            end else if (disturb && k == 4) begin
                bus.start = 1'b0; bus.mtlo = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        chk("latency", k, lat);
        chk("busy_and_hold", ok, 1);
        chk("hi", bus.hi, e[63:32]);
        chk("lo", bus.lo, e[31:0]);
        chk("div_by_zero", bus.div_by_zero, e[64]);
        chk("busy_in_done", bus.busy, 0);
        hi_m = e[63:32];
        lo_m = e[31:0];
        d = $urandom;
        if (mt_in_done) begin
            bus.mthi = 1'b1; bus.mt_data = d;
        end
        @(negedge clk);
        bus.mthi = 1'b0;
        chk("done_one_cycle", bus.done, 0);
        chk("dbz_one_cycle", bus.div_by_zero, 0);
        if (mt_in_done) begin
            hi_m = d;
            chk("mthi_in_done", bus.hi, d);
        end
    endtask

    task automatic mt_write(input bit h, input bit l, input logic [31:0] d);
        @(negedge clk);
        bus.mthi = h; bus.mtlo = l; bus.mt_data = d;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.mt_data = $urandom;
        if (h) hi_m = d;
        if (l) lo_m = d;
        chk("mt_hi", bus.hi, hi_m);
        chk("mt_lo", bus.lo, lo_m);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0] rop;
        logic [3:0] ops [4];
        bit         saw_done;
        checks = 0; errors = 0;
        hi_m = '0; lo_m = '0;
        ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;
        clk = 1'b0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = '0; bus.op1 = '0; bus.op2 = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.mt_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        rst_n = 1'b1;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        chk("multu_max_hi", hi_m, 64'hFFFF_FFFE);
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7, 0, 1, 0);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 0, 0, 1);
        run_op(OP_DIVU,  32'd100, 32'd7, 0, 0, 0);
        run_op(OP_DIVU,  32'd100, 32'd0, 0, 0, 0);

        mt_write(1, 0, 32'h1234_5678);
        mt_write(0, 1, 32'hCAFE_F00D);
        mt_write(1, 1, 32'h0BAD_BEEF);
        run_op(OP_DIVU,  32'd1000, 32'd33, 1, 0, 0);

        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'b0011; bus.op1 = 32'd5; bus.op2 = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        chk("invalid_op_busy", bus.busy, 0);
        @(negedge clk);
        chk("invalid_op_done", bus.done, 0);
        chk("invalid_op_hi", bus.hi, hi_m);

        @(negedge clk);
`ifdef FAST_MULT_EN
        bus.op = OP_DIVU;
`else
        bus.op = OP_MULTU;
`endif
        bus.start = 1'b1; bus.op1 = 32'hDEAD_BEEF; bus.op2 = 32'h1234_5678;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_hi", bus.hi, 0);
        chk("abort_lo", bus.lo, 0);
        hi_m = '0; lo_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 0);
        run_op(OP_MULTU, 32'd12345, 32'd6789, 0, 0, 0);

        for (int n = 0; n < 24; n++) begin
            rop = ops[$urandom_range(0, 3)];
            run_op(rop, pick_operand(), pick_operand(), 0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
